// File: rtl/systolic_ws_pkg.sv
// Shared types and parameter helpers for the weight-stationary tile sequencer.
package systolic_ws_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      STREAM,
      DRAIN,
      DONE
   } state_e;

   // One issue stage plus datapath latency plus the longest deskew chain
   function automatic int unsigned tag_depth(input int unsigned pipe_lat,
                                             input int unsigned col_num);
      return 1 + pipe_lat + col_num - 1;
   endfunction

   // Row address width; a single-row tile still gets a 1-bit address
   function automatic int unsigned addr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/systolic_skew_buf.sv
// Zero-reset delay line used for lane skew and column deskew; DEPTH=0 degenerates to a wire.
module systolic_skew_buf #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic w_unused_ok;
         assign w_unused_ok = &{1'b0, clk, reset};
         assign o_q = i_d;
      end else begin : g_pipe
         logic [WIDTH-1:0] r_pipe [DEPTH];

         always_ff @(posedge clk) begin
            if (!reset) begin
               for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
            end else begin
               r_pipe[0] <= i_d;
               for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
            end
         end

         assign o_q = r_pipe[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/systolic_ws_ctrl.sv
// Tile sequencer: loads weights, streams source rows skewed onto the datapath wests,
// deskews the souths and writes one result row per cycle, tracked by a valid/row tag pipe.
module systolic_ws_ctrl
   import systolic_ws_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ROW_NUM    = 8,
   parameter int unsigned COL_NUM    = 8,
   parameter int unsigned LENGTH     = 8,
   parameter int unsigned PIPE_LAT   = 8,
   localparam int unsigned ROW_ADDR_WIDTH = addr_width(ROW_NUM)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   output logic                              busy,
   output logic                              done,
   output logic                              wt_load,
   output logic                              src_rden,
   output logic [ROW_ADDR_WIDTH-1:0]         src_rdaddr,
   input  logic [DATA_WIDTH*LENGTH-1:0]      src_rddata,
   output logic [DATA_WIDTH*LENGTH-1:0]      dp_wests,
   input  logic [DATA_WIDTH*4*COL_NUM-1:0]   dp_souths,
   output logic                              res_wren,
   output logic [ROW_ADDR_WIDTH-1:0]         res_wraddr,
   output logic [DATA_WIDTH*4*COL_NUM-1:0]   res_wrdata
);

   localparam int unsigned RES_W = DATA_WIDTH * 4;
   localparam int unsigned TAG_D = tag_depth(PIPE_LAT, COL_NUM);
   localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(ROW_NUM - 1);

   state_e                      r_state;
   state_e                      w_state_nxt;
   logic [ROW_ADDR_WIDTH-1:0]   w_addr_nxt;
   logic                        r_busy;
   logic                        r_done;
   logic                        r_wt_load;
   logic                        r_src_rden;
   logic [ROW_ADDR_WIDTH-1:0]   r_src_rdaddr;
   logic                        r_rd_vld;

   logic [TAG_D-1:0]            r_tag_vld;
   logic [ROW_ADDR_WIDTH-1:0]   r_tag_row [TAG_D];
   logic                        w_tag_vld;
   logic [ROW_ADDR_WIDTH-1:0]   w_tag_row;

   logic [DATA_WIDTH*4*COL_NUM-1:0] w_deskew;

   assign w_tag_vld = r_tag_vld[TAG_D-1];
   assign w_tag_row = r_tag_row[TAG_D-1];

   // Next-state and issue address
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_src_rdaddr;
      unique case (r_state)
         IDLE: begin
            if (start) w_state_nxt = LOAD_W;
         end
         LOAD_W: begin
            w_state_nxt = STREAM;
            w_addr_nxt  = '0;
         end
         STREAM: begin
            if (r_src_rdaddr == LAST_ROW) begin
               w_state_nxt = DRAIN;
               w_addr_nxt  = '0;
            end else begin
               w_addr_nxt = r_src_rdaddr + ROW_ADDR_WIDTH'(1);
            end
         end
         DRAIN: begin
            if (w_tag_vld && (w_tag_row == LAST_ROW)) w_state_nxt = DONE;
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register with outputs decoded from the next state
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_wt_load    <= 1'b0;
         r_src_rden   <= 1'b0;
         r_src_rdaddr <= '0;
         r_rd_vld     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_busy       <= (w_state_nxt != IDLE);
         r_done       <= (w_state_nxt == DONE);
         r_wt_load    <= (w_state_nxt == LOAD_W);
         r_src_rden   <= (w_state_nxt == STREAM);
         r_src_rdaddr <= w_addr_nxt;
         r_rd_vld     <= r_src_rden;
      end
   end

   // Write tags follow each issued row through SRAM read, datapath and deskew
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_tag_vld <= '0;
         for (int i = 0; i < TAG_D; i++) r_tag_row[i] <= '0;
      end else begin
         r_tag_vld[0] <= r_src_rden;
         r_tag_row[0] <= r_src_rden ? r_src_rdaddr : '0;
         for (int i = 1; i < TAG_D; i++) begin
            r_tag_vld[i] <= r_tag_vld[i-1];
            r_tag_row[i] <= r_tag_row[i-1];
         end
      end
   end

   genvar k;
   generate
      for (k = 0; k < LENGTH; k++) begin : g_skew
         logic [DATA_WIDTH-1:0] w_lane_in;
         // Lanes read zero outside valid rows so stale SRAM data never enters the array
         assign w_lane_in = r_rd_vld ? src_rddata[k*DATA_WIDTH +: DATA_WIDTH] : '0;
         systolic_skew_buf #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (k)
         ) u_skew (
            .clk   (clk),
            .reset (reset),
            .i_d   (w_lane_in),
            .o_q   (dp_wests[k*DATA_WIDTH +: DATA_WIDTH])
         );
      end

      for (k = 0; k < COL_NUM; k++) begin : g_deskew
         systolic_skew_buf #(
            .WIDTH (RES_W),
            .DEPTH (COL_NUM - 1 - k)
         ) u_deskew (
            .clk   (clk),
            .reset (reset),
            .i_d   (dp_souths[k*RES_W +: RES_W]),
            .o_q   (w_deskew[k*RES_W +: RES_W])
         );
      end
   endgenerate

   assign busy       = r_busy;
   assign done       = r_done;
   assign wt_load    = r_wt_load;
   assign src_rden   = r_src_rden;
   assign src_rdaddr = r_src_rdaddr;
   assign res_wren   = w_tag_vld;
   assign res_wraddr = w_tag_vld ? w_tag_row : '0;
   assign res_wrdata = w_tag_vld ? w_deskew : '0;

endmodule

// File: tb/tb_systolic_ws_ctrl.sv
// Directed bench for systolic_ws_ctrl: 4x4 tile with an identity-weight datapath model,
// plus a single-row instance.
module tb_systolic_ws_ctrl;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          busy, done, wt_load, src_rden, res_wren;
   logic [1:0]    src_rdaddr, res_wraddr;
   logic [31:0]   src_rddata;
   logic [31:0]   dp_wests;
   logic [127:0]  dp_souths;
   logic [127:0]  res_wrdata;

   logic          start1;
   logic          busy1, done1, wt_load1, src_rden1, res_wren1;
   logic [0:0]    src_rdaddr1, res_wraddr1;
   logic [31:0]   src_rddata1;
   logic [31:0]   dp_wests1;
   logic [127:0]  dp_souths1;
   logic [127:0]  res_wrdata1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   systolic_ws_ctrl #(
      .DATA_WIDTH (DW), .ROW_NUM (4), .COL_NUM (4), .LENGTH (4), .PIPE_LAT (4)
   ) u_dut (
      .clk (clk), .reset (reset), .start (start), .busy (busy), .done (done),
      .wt_load (wt_load), .src_rden (src_rden), .src_rdaddr (src_rdaddr),
      .src_rddata (src_rddata), .dp_wests (dp_wests), .dp_souths (dp_souths),
      .res_wren (res_wren), .res_wraddr (res_wraddr), .res_wrdata (res_wrdata)
   );

   systolic_ws_ctrl #(
      .DATA_WIDTH (DW), .ROW_NUM (1), .COL_NUM (4), .LENGTH (4), .PIPE_LAT (4)
   ) u_dut1 (
      .clk (clk), .reset (reset), .start (start1), .busy (busy1), .done (done1),
      .wt_load (wt_load1), .src_rden (src_rden1), .src_rdaddr (src_rdaddr1),
      .src_rddata (src_rddata1), .dp_wests (dp_wests1), .dp_souths (dp_souths1),
      .res_wren (res_wren1), .res_wraddr (res_wraddr1), .res_wrdata (res_wrdata1)
   );

   function automatic logic [7:0] row_lane(input int r, input int k);
      return 8'(4 * r + k + 1);
   endfunction

   function automatic logic [127:0] exp_row(input int r);
      logic [127:0] v;
      v = '0;
      for (int j = 0; j < 4; j++) v[j*32 +: 32] = 32'(row_lane(r, j));
      return v;
   endfunction

   // Source SRAM: one-cycle read latency, junk on idle cycles
   always @(posedge clk) begin
      if (src_rden) begin
         for (int k = 0; k < 4; k++) src_rddata[k*8 +: 8] <= row_lane(int'(src_rdaddr), k);
      end else begin
         src_rddata <= $urandom;
      end
   end

   // Identity-weight datapath: souths column j = west lane j delayed PIPE_LAT cycles
   logic [31:0] dl [4];
   always @(posedge clk) begin
      dl[0] <= dp_wests;
      for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
   end
   always_comb begin
      dp_souths = '0;
      for (int j = 0; j < 4; j++) dp_souths[j*32 +: 32] = {24'd0, dl[3][j*8 +: 8]};
   end

   assign src_rddata1 = 32'h04030201;
   assign dp_souths1  = 128'h0000_00dd_0000_00cc_0000_00bb_0000_00aa;

   typedef struct {
      logic         wt_load;
      logic         src_rden;
      logic [1:0]   rdaddr;
      logic         busy;
      logic         done;
      logic         wren;
      logic [1:0]   wraddr;
      logic [31:0]  wests;
      logic [127:0] wrdata;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string nm, input int t, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0d got=%0h exp=%0h", nm, t, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic build_table();
      for (int t = 0; t < 17; t++) begin
         tbl[t].wt_load  = (t == 1);
         tbl[t].src_rden = (t >= 2 && t <= 5);
         tbl[t].rdaddr   = (t >= 2 && t <= 5) ? 2'(t - 2) : 2'd0;
         tbl[t].busy     = (t >= 1 && t <= 14);
         tbl[t].done     = (t == 14);
         tbl[t].wren     = (t >= 10 && t <= 13);
         tbl[t].wraddr   = (t >= 10 && t <= 13) ? 2'(t - 10) : 2'd0;
         tbl[t].wrdata   = (t >= 10 && t <= 13) ? exp_row(t - 10) : '0;
         tbl[t].wests    = '0;
         for (int k = 0; k < 4; k++) begin
            if (t - 3 - k >= 0 && t - 3 - k < 4) tbl[t].wests[k*8 +: 8] = row_lane(t - 3 - k, k);
         end
      end
   endtask

   task automatic check_vec(input int t);
      chk("wt_load",  t, wt_load,    tbl[t].wt_load);
      chk("src_rden", t, src_rden,   tbl[t].src_rden);
      chk("rdaddr",   t, src_rdaddr, tbl[t].rdaddr);
      chk("busy",     t, busy,       tbl[t].busy);
      chk("done",     t, done,       tbl[t].done);
      chk("wren",     t, res_wren,   tbl[t].wren);
      chk("wraddr",   t, res_wraddr, tbl[t].wraddr);
      chk("wests",    t, dp_wests,   tbl[t].wests);
      chk("wrdata",   t, res_wrdata, tbl[t].wrdata);
   endtask

   task automatic run_nominal();
      check_vec(0);
      start = 1'b1;
      for (int t = 1; t < 17; t++) begin
         step();
         start = 1'b0;
         check_vec(t);
      end
   endtask

   int n_wr, n_dn, n_wl, addr_bad, wl_t0, wl_t1, dn_t0, dn_t1;

   initial begin
      reset  = 1'b0;
      start  = 1'b0;
      start1 = 1'b0;
      build_table();

      // Reset state
      for (int i = 0; i < 3; i++) step();
      chk("rst_busy",  0, {busy, busy1}, 2'b00);
      chk("rst_ctl",   0, {done, wt_load, src_rden, res_wren}, 4'h0);
      chk("rst_ctl1",  0, {done1, wt_load1, src_rden1, res_wren1}, 4'h0);
      chk("rst_addr",  0, {src_rdaddr, res_wraddr, src_rdaddr1, res_wraddr1}, 6'h0);
      chk("rst_wests", 0, {dp_wests, dp_wests1}, 64'h0);
      chk("rst_wdata", 0, res_wrdata | res_wrdata1, 128'h0);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) step();

      // Nominal tile with full per-cycle vectors, including lane skew
      run_nominal();
      step();

      // Start pulsed during STREAM is ignored
      n_wr = 0; n_dn = 0; n_wl = 0; addr_bad = 0;
      start = 1'b1;
      for (int t = 1; t <= 20; t++) begin
         step();
         start = (t == 5);
         if (wt_load) n_wl++;
         if (done) n_dn++;
         if (res_wren) begin
            if (int'(res_wraddr) != n_wr) addr_bad++;
            n_wr++;
         end
      end
      start = 1'b0;
      chk("ign_writes", 0, n_wr, 4);
      chk("ign_done",   0, n_dn, 1);
      chk("ign_wtload", 0, n_wl, 1);
      chk("ign_order",  0, addr_bad, 0);
      step();

      // Back-to-back with start held high
      n_wl = 0; n_dn = 0; wl_t0 = -1; wl_t1 = -1; dn_t0 = -1; dn_t1 = -1;
      start = 1'b1;
      for (int t = 1; t <= 34; t++) begin
         step();
         if (wt_load) begin
            n_wl++;
            if (n_wl == 1) wl_t0 = t;
            else begin
               wl_t1 = t;
               start = 1'b0;
            end
         end
         if (done) begin
            n_dn++;
            if (n_dn == 1) dn_t0 = t; else dn_t1 = t;
         end
      end
      chk("b2b_wl0", 0, wl_t0, 1);
      chk("b2b_wl1", 0, wl_t1, 16);
      chk("b2b_dn0", 0, dn_t0, 14);
      chk("b2b_dn1", 0, dn_t1, 29);
      chk("b2b_cnt", 0, {n_wl[7:0], n_dn[7:0]}, 16'h0202);
      step();

      // Reset in mid-tile aborts it
      n_wr = 0; n_dn = 0; addr_bad = 0;
      start = 1'b1;
      for (int t = 1; t <= 25; t++) begin
         step();
         start = 1'b0;
         if (res_wren) begin
            n_wr++;
            if (res_wraddr >= 2'd2) addr_bad++;
         end
         if (done) n_dn++;
         if (t == 11) reset = 1'b0;
         if (t == 12) begin
            chk("abort_ctl",   t, {busy, done, wt_load, src_rden, res_wren}, 5'h0);
            chk("abort_addr",  t, {src_rdaddr, res_wraddr}, 4'h0);
            chk("abort_wests", t, dp_wests, 32'h0);
            chk("abort_wdata", t, res_wrdata, 128'h0);
            reset = 1'b1;
         end
      end
      chk("abort_writes", 0, n_wr, 2);
      chk("abort_late",   0, addr_bad, 0);
      chk("abort_done",   0, n_dn, 0);
      step();
      run_nominal();
      step();

      // Single-row instance
      n_wr = 0;
      start1 = 1'b1;
      for (int t = 1; t <= 13; t++) begin
         step();
         start1 = 1'b0;
         chk("r1_wtload", t, wt_load1, t == 1);
         chk("r1_rden",   t, src_rden1, t == 2);
         chk("r1_busy",   t, busy1, t >= 1 && t <= 11);
         chk("r1_done",   t, done1, t == 11);
         chk("r1_wren",   t, res_wren1, t == 10);
         if (t == 3) chk("r1_wests3", t, dp_wests1, 32'h00000001);
         if (t == 4) chk("r1_wests4", t, dp_wests1, 32'h00000200);
         if (res_wren1) begin
            n_wr++;
            chk("r1_addr", t, res_wraddr1, 1'b0);
            chk("r1_data", t, res_wrdata1, dp_souths1);
         end
      end
      chk("r1_writes", 0, n_wr, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
